// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart receive path
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchronizer with selectable reset value
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling serial receiver with framing-error detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt, ferr_nxt;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (!rx_s) state_nxt = START;
                end
                START: begin
                    // Re-check mid start bit so short low glitches are ignored
                    if (cnt == HALF_M1) begin
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt_nxt   = '0;
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        idx_nxt   = idx + 3'd1;
                        if (idx == LAST_IDX) state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt_nxt = '0;
                        if (rx_s) begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not be mistaken for new start bits
                    cnt_nxt = '0;
                    if (rx_s) state_nxt = IDLE;
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
